// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the processor register file.
// Walks every register index through a combinational read port and streams
// each captured word out on a valid/ready interface together with its index.
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum word
// (index NUM_REGS) after the last register.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_CSUM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
`endif

    // Index of the last register word, and of the word that carries out_last.
    localparam logic [ADDR_W:0] LAST_REG  = (ADDR_W+1)'(NUM_REGS - 1);
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [ADDR_W:0] FINAL_IDX = (ADDR_W+1)'(NUM_REGS);
`else
    localparam logic [ADDR_W:0] FINAL_IDX = LAST_REG;
`endif
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W:0]     index_q, index_d;
    logic                done_q, done_d;
    logic                fire;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
`endif

    assign fire = valid_q & out_ready;

    // Next-state logic: capture rd_data for the word at ptr on each accepted handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        done_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                ptr_d   = '0;
                valid_d = 1'b0;
                if (start) begin
                    // rd_addr is 0 in IDLE, so rd_data is register 0 here.
                    data_d  = rd_data;
                    index_d = '0;
                    valid_d = 1'b1;
                    ptr_d   = PTR_ONE;
                    state_d = S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_SEND: begin
                if (fire) begin
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d = acc_q ^ data_q;
`endif
                    if (index_q < LAST_REG) begin
                        data_d  = rd_data;
                        index_d = ptr_q;
                        ptr_d   = ptr_q + PTR_ONE;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        // Checksum includes the final register word being accepted now.
                        data_d  = acc_q ^ data_q;
                        index_d = FINAL_IDX;
                        state_d = S_CSUM;
`else
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (fire) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            done_q  <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // ptr may reach NUM_REGS; the top bit is dropped so the read stays in range.
    assign rd_addr   = ptr_q[ADDR_W-1:0];
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = valid_q & (index_q == FINAL_IDX);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed testbench for regfile_dump with a behavioural 32x32 register file.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NWORDS = 33;
`else
    localparam int NWORDS = 32;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rf [0:31];
    logic [31:0] exp_data [0:32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Register file model: preloaded with i*0x01010101 on reset, one write port.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h0101_0101;
        end else if (we) begin
            rf[wa] <= wd;
        end
    end
    assign rd_data = rf[rd_addr];

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void calc_csum();
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 32; i++) x = x ^ exp_data[i];
        exp_data[32] = x;
    endfunction

    function automatic void init_exp();
        for (int i = 0; i < 32; i++) exp_data[i] = 32'(i) * 32'h0101_0101;
        calc_csum();
    endfunction

    // Consume one dump whose first word is already presented.
    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
    // wr_idx > 0: write 0xDEADBEEF to that register on the edge it is captured.
    // st_idx >= 0: pulse start while that index is presented.
    // abort_idx >= 0: assert reset on the edge that index is accepted.
    task automatic dump(input int mode, input int wr_idx, input int st_idx,
                        input int abort_idx, input string tag);
        int          got;
        int          cyc;
        int          ph;
        bit          stalled;
        bit          fire;
        bit          abort;
        logic [31:0] hd;
        logic [5:0]  hi;
        got = 0; cyc = 0; ph = 0; stalled = 1'b0;
        while (got < NWORDS && cyc < 500) begin
            if (stalled) begin
                chk({tag, " hold data"}, out_data, hd);
                chk({tag, " hold index"}, 32'(out_index), 32'(hi));
            end
            out_ready = (mode == 0) ? 1'b1 : ((ph % 4) == 0 || (ph % 4) == 3);
            ph++;
            fire  = out_valid && out_ready;
            start = (st_idx >= 0) && out_valid && (int'(out_index) == st_idx);
            abort = fire && (int'(out_index) == abort_idx);
            if (fire && wr_idx > 0 && int'(out_index) == wr_idx - 1) begin
                we = 1'b1;
                wa = 5'(wr_idx);
                wd = 32'hDEAD_BEEF;
            end
            if (fire) begin
                chk({tag, " index"}, 32'(out_index), 32'(got));
                chk({tag, " data"}, out_data, exp_data[got]);
                chk({tag, " last"}, 32'(out_last), 32'(got == NWORDS - 1));
                chk({tag, " busy"}, 32'(busy), 32'd1);
                got++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data;
            hi = out_index;
            reset = abort;
            tick();
            start = 1'b0;
            we    = 1'b0;
            reset = 1'b0;
            cyc++;
            if (abort) return;
        end
        chk({tag, " word count"}, 32'(got), 32'(NWORDS));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " busy low"}, 32'(busy), 32'd0);
        chk({tag, " valid low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        init_exp();
        tick();
        tick();
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst rd_addr", 32'(rd_addr), 32'd0);
        chk("rst data", out_data, 32'd0);
        chk("rst index", 32'(out_index), 32'd0);
        chk("rst last", 32'(out_last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle valid", 32'(out_valid), 32'd0);

        // Basic dump with ready held high.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first valid", 32'(out_valid), 32'd1);
        chk("first index", 32'(out_index), 32'd0);
        chk("first rd_addr", 32'(rd_addr), 32'd1);
        chk("first busy", 32'(busy), 32'd1);
        dump(0, -1, -1, -1, "basic");
        chk_done("basic");
        tick();
        chk("basic done clear", 32'(done), 32'd0);

        // Backpressure, then a back-to-back start in the done cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        dump(1, -1, -1, -1, "bp");
        chk_done("bp");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b valid", 32'(out_valid), 32'd1);
        chk("b2b index", 32'(out_index), 32'd0);
        chk("b2b data", out_data, exp_data[0]);

        // Concurrent write to reg 5 on its capture edge: old value streamed.
        dump(0, 5, -1, -1, "cwr");
        chk_done("cwr");
        exp_data[5] = 32'hDEAD_BEEF;
        calc_csum();
        tick();

        // Second dump sees the new value; start pulsed at index 7 is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        dump(0, -1, 7, -1, "busystart");
        chk_done("busystart");
        tick();
        chk("busystart done once", 32'(done), 32'd0);
        tick();
        chk("busystart no restart", 32'(out_valid), 32'd0);
        chk("busystart done idle", 32'(done), 32'd0);

        // Reset after index 10 is accepted aborts the dump.
        start = 1'b1;
        tick();
        start = 1'b0;
        dump(0, -1, -1, 10, "abort");
        init_exp();
        chk("abort valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort index", 32'(out_index), 32'd0);
        chk("abort data", out_data, 32'd0);
        chk("abort rd_addr", 32'(rd_addr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort no done", 32'(done), 32'd0);
        end

        // Restart after the abort begins at index 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart index", 32'(out_index), 32'd0);
        chk("restart data", out_data, exp_data[0]);
        dump(0, -1, -1, -1, "restart");
        chk_done("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 32×32 processor register file. On a `start` pulse it walks every register index through one of the register file's combinational read ports. It captures each word and streams it out on a valid/ready interface with its index, so a bench or debug UART can snapshot the architectural state. It is the reader-side counterpart to the writeback path and sits beside the register file, sharing a read-address mux with the decode stage.

## Interface
Parameters:
- `NUM_REGS`, 32: number of registers walked; indices 0..NUM_REGS-1.
- `ADDR_W`, 5: register address width; NUM_REGS ≤ 2^ADDR_W.
- `DATA_W`, 32: register data width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a dump; sampled only in IDLE.
- `rd_addr` out ADDR_W: read address to the register file port; registered.
- `rd_data` in DATA_W: combinational read data for `rd_addr`.
- `out_valid` out 1: `out_data`/`out_index`/`out_last` hold a valid word.
- `out_ready` in 1: consumer accepts the word when high with `out_valid`.
- `out_data` out DATA_W: captured register value (or checksum, see Configuration).
- `out_index` out ADDR_W+1: index of the word; widened by one bit to encode NUM_REGS.
- `out_last` out 1: marks the final word of the dump.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse after the final word is accepted.

## Operation
- The state machine has states IDLE, SEND, and CSUM. CSUM exists only with the macro.
- `ptr` (ADDR_W+1 bits) drives `rd_addr = ptr[ADDR_W-1:0]`. It always holds the index of the next word to fetch.
- **IDLE:**
  - `ptr`=0 and `out_valid`=0.
  - On `start`, the block loads `out_data`←`rd_data` (reg 0) and `out_index`←0, sets `out_valid`←1 and `ptr`←1, and moves to SEND.
- **SEND:**
  - A handshake ("fire") occurs when `out_valid`&`out_ready`.
  - On fire with `out_index` < NUM_REGS-1, the block loads `out_data`←`rd_data`, `out_index`←`ptr`, and `ptr`←`ptr`+1.
  - On fire with `out_index` = NUM_REGS-1: without the macro, the block clears `out_valid`, pulses `done`, and goes to IDLE. With the macro, it goes to CSUM.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index`, and `out_last` are held stable. `ptr` is also held.
- `out_last` = (`out_index` == final index) & `out_valid`.
- `start` is ignored outside IDLE. `out_ready` is ignored while `out_valid`=0.
- **Coherency:** each word is sampled on its capture edge. A register-file write on that same edge is not seen; the pre-write value is captured. The dump is not atomic across registers.

## Timing
- **Reset values:** state=IDLE; `rd_addr`=0, `ptr`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0. Checksum accumulator=0.
- `start` sampled at edge N gives `out_valid`=1 with reg 0 after edge N, i.e. a latency of 1 cycle.
- With `out_ready` held high, the block sends one word per cycle. NUM_REGS words occupy NUM_REGS consecutive cycles, plus 1 cycle for the checksum word with the macro.
- `done` is high for exactly the one cycle after the final fire edge. `busy` drops in that same cycle.
- A `start` in the same cycle as `done` is accepted, because state is IDLE. This gives back-to-back dumps with a 1-cycle gap.
- `reset` mid-dump aborts immediately. All outputs return to reset values on the next edge and no `done` is issued.
- `ptr` reaching NUM_REGS never drives `rd_addr` out of range. `rd_addr` is masked and that read is unused.

## Configuration
- `REGDUMP_CHECKSUM_EN`:
  - **Defined:** the block keeps an XOR accumulator. It is cleared on `start` and XORs in `out_data` on every fire in SEND. After the NUM_REGS-1 fire it enters CSUM and presents `out_data`=accumulator, `out_index`=NUM_REGS, `out_last`=1. On the fire of that word it pulses `done` and returns to IDLE.
  - **Undefined:** there is no accumulator and no CSUM state, and `out_last` is asserted on index NUM_REGS-1.

## Test plan
- **Basic dump:** preload reg i = i·0x0101_0101 (reg0=0), `start` 1 cycle, `out_ready`=1. Expect 32 words on consecutive cycles with index 0..31 and matching data, `out_last` only on index 31, and `done` 1 cycle after it. With the macro, expect a 33rd word at index 32 with data = XOR of all values = 0x0000_0000.
- **Backpressure:** toggle `out_ready` 1,0,0,1 repeating. Every word is accepted exactly once in order, and data/index stay stable during stalls.
- **Concurrent write:** write 0xDEADBEEF to reg 5 on the same edge that reg 5 is captured. Expect the old value 0x05050505 streamed; then a second dump shows 0xDEADBEEF.
- **Reset mid-dump:** assert `reset` after index 10 is accepted. Next cycle `out_valid`=0, `busy`=0, and `done` is never pulsed. A new `start` then restarts at index 0.
- **Start while busy:** pulse `start` at index 7. No effect: the sequence continues 8..31 and a single `done` is issued.
- **Back-to-back:** assert `start` in the `done` cycle. The second dump begins the next cycle at index 0.
